// File: rtl/rr_bus_scheduler.sv
// rtl/rr_bus_scheduler.sv - round-robin N-master bus scheduler with hold-limit preemption
// Grants one master at a time and keeps the bus parked in RELEASE until every slave is ready.
module rr_bus_scheduler #(
    parameter int NUM_MASTERS = 4,
    parameter int MSEL_W      = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int MAX_HOLD    = 16,
    parameter int HOLD_W      = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] breq,
    input  logic [NUM_SLAVES-1:0]  sready,
    output logic [NUM_MASTERS-1:0] bgrant,
    output logic [MSEL_W-1:0]      msel,
    output logic                   bus_busy,
    output logic                   preempt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam bit                PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LIM   = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = {HOLD_W{1'b1}};

    logic [1:0]             state_q, state_d;
    logic [MSEL_W-1:0]      owner_q, owner_d;
    logic [MSEL_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   preempt_q, preempt_d;

    logic                   sready_all;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic                   others_req;
    logic                   arb_found;
    logic [MSEL_W-1:0]      arb_idx;
    logic [MSEL_W-1:0]      arb_cand;

    assign sready_all = &sready;
    assign owner_oh   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner_q;
    assign others_req = |(breq & ~owner_oh);

    // Search starts just after the last winner so it has lowest priority next time.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            arb_cand = MSEL_W'((int'(rr_ptr_q) + i) % NUM_MASTERS);
            if (!arb_found && breq[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d  = ST_GRANT;
                    owner_d  = arb_idx;
                    rr_ptr_d = arb_idx;
                    hold_d   = '0;
                end
            end
            ST_GRANT: begin
                if (!breq[owner_q]) begin
                    state_d = ST_RELEASE;
                end else if (PREEMPT_EN && (hold_q >= HOLD_LIM) && others_req) begin
                    // >= rather than == so a long sole-owner tenure is still revocable once others arrive
                    state_d   = ST_RELEASE;
                    preempt_d = 1'b1;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (sready_all) begin
                    if (arb_found) begin
                        state_d  = ST_GRANT;
                        owner_d  = arb_idx;
                        rr_ptr_d = arb_idx;
                        hold_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= MSEL_W'(NUM_MASTERS - 1);
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign bgrant   = (state_q == ST_GRANT) ? owner_oh : '0;
    assign msel     = owner_q;
    assign bus_busy = (state_q != ST_IDLE);
    assign preempt  = preempt_q;

endmodule

// File: tb/tb_rr_bus_scheduler.sv
// tb/tb_rr_bus_scheduler.sv - scoreboard bench for rr_bus_scheduler
module tb_rr_bus_scheduler;

    localparam int N  = 4;
    localparam int NS = 3;
    localparam int MH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  breq = '0;
    logic [NS-1:0] sready = '1;
    logic [N-1:0]  bgrant;
    logic [1:0]    msel;
    logic          bus_busy;
    logic          preempt;

    int checks = 0;
    int errors = 0;

    rr_bus_scheduler #(
        .NUM_MASTERS(N), .MSEL_W(2), .NUM_SLAVES(NS), .MAX_HOLD(MH), .HOLD_W(5)
    ) dut (
        .clk(clk), .rst(rst), .breq(breq), .sready(sready),
        .bgrant(bgrant), .msel(msel), .bus_busy(bus_busy), .preempt(preempt)
    );

    always #5 clk = ~clk;

    // Reference: who holds the bus, how long, and who won last.
    int  m_phase;      // 0 = bus free, 1 = owned, 2 = draining before next grant
    int  m_owner;
    int  m_last_win;
    int  m_tenure;
    bit  m_revoked;

    logic [7:0] sb[$];

    function automatic int next_winner(logic [N-1:0] req, int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int waiting_others(logic [N-1:0] req, int own);
        int c = 0;
        for (int m = 0; m < N; m++) if (req[m] && m != own) c++;
        return c;
    endfunction

    function automatic logic [7:0] expected_now();
        logic [N-1:0] g;
        logic [1:0]   ms;
        g  = (m_phase == 1) ? N'(1 << m_owner) : '0;
        ms = 2'(m_owner);
        return {g, ms, 1'(m_phase != 0), m_revoked};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last_win = N - 1; m_tenure = 0; m_revoked = 0;
    endtask

    task automatic take_bus(int w);
        m_phase = 1; m_owner = w; m_last_win = w; m_tenure = 0;
    endtask

    task automatic model_step(logic [N-1:0] req, logic [NS-1:0] rdy);
        int w;
        m_revoked = 0;
        if (m_phase == 0) begin
            w = next_winner(req, m_last_win);
            if (w >= 0) take_bus(w);
        end else if (m_phase == 1) begin
            if (!req[m_owner]) m_phase = 2;
            else if (MH != 0 && m_tenure + 1 >= MH && waiting_others(req, m_owner) > 0) begin
                m_phase = 2; m_revoked = 1;
            end else m_tenure++;
        end else if (rdy == '1) begin
            w = next_winner(req, m_last_win);
            if (w >= 0) take_bus(w); else m_phase = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
                sb.delete();
            end else begin
                model_step(breq, sready);
            end
            sb.push_back(expected_now());
        end
    end

    bit mon_en = 0;
    initial begin
        logic [7:0] e;
        logic [7:0] got;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {bgrant, msel, bus_busy, preempt};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got bgrant=%b msel=%0d busy=%b preempt=%b, expected bgrant=%b msel=%0d busy=%b preempt=%b",
                             $time, got[7:4], got[3:2], got[1], got[0], e[7:4], e[3:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    int preempt_seen = 0;
    initial forever begin
        @(negedge clk);
        if (!rst && preempt) preempt_seen++;
    end

    initial begin
        #1 rst = 1'b1;
        mon_en = 1;
        #1;
        check("reset_bgrant", 32'(bgrant), 32'h0);
        check("reset_busy", 32'(bus_busy), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single master grant then release
        breq = 4'b0001;
        @(negedge clk);
        check("t1_bgrant", 32'(bgrant), 32'h1);
        check("t1_busy", 32'(bus_busy), 32'h1);
        breq = 4'b0000;
        repeat (3) @(negedge clk);
        check("t1_idle_msel", 32'(msel), 32'h0);
        check("t1_idle_busy", 32'(bus_busy), 32'h0);

        // all request: rotation with preemption
        breq = 4'b1111;
        repeat (75) @(negedge clk);
        check("t2_preempts", 32'(preempt_seen), 32'd4);

        // stuck release while a slave is not ready
        breq = 4'b0000;
        repeat (3) @(negedge clk);
        breq = 4'b0100;
        repeat (3) @(negedge clk);
        breq = 4'b0000; sready = 3'b101;
        repeat (4) @(negedge clk);
        breq = 4'b1000;
        repeat (4) @(negedge clk);
        check("t3_parked", 32'(bgrant), 32'h0);
        sready = 3'b111;
        repeat (2) @(negedge clk);
        check("t3_regrant", 32'(bgrant), 32'h8);
        breq = 4'b0000;
        repeat (3) @(negedge clk);

        // sole requester is never preempted, then a competitor arrives
        preempt_seen = 0;
        breq = 4'b0100;
        repeat (40) @(negedge clk);
        check("t4_no_preempt", 32'(preempt_seen), 32'd0);
        check("t4_still_owner", 32'(bgrant), 32'h4);
        breq = 4'b0101;
        repeat (4) @(negedge clk);
        check("t4_preempt_then_0", 32'(bgrant), 32'h1);
        breq = 4'b0000;
        repeat (3) @(negedge clk);

        // async reset in the middle of a grant
        breq = 4'b1111;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_bgrant", 32'(bgrant), 32'h0);
        check("t6_msel", 32'(msel), 32'h0);
        check("t6_busy", 32'(bus_busy), 32'h0);
        @(negedge clk);
        breq = 4'b1010;
        rst = 1'b0;
        @(negedge clk);
        check("t6_first_win", 32'(bgrant), 32'h2);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int m = 0; m < N; m++)
                if ($urandom_range(39) == 0) breq[m] = ~breq[m];
            sready = ($urandom_range(5) == 0) ? NS'($urandom_range(7)) : '1;
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
